cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Board-side run controller for the pipelined CPU core. Sits between the push-buttons
//  and the core: drives the core's global enable (en), and consumes the core's WB-stage
//  status outputs (is_jump, is_branch, branched, halt).
//  Provides run / single-step / pause control, sticky halt and saturating statistics counters.
// PARAMETERS
//  CntBits   32   width of every statistics counter (>=2)
// PORTS
//  clk         in   1        system clock, same clock as the core
//  rst_n       in   1        asynchronous active-low reset
//  btn_run     in   1        run request, level (already synchronized and debounced)
//  btn_step    in   1        single-step request, level (synchronized, debounced)
//  btn_pause   in   1        pause request, level (synchronized, debounced)
//  stats_clr   in   1        synchronous clear of all counters, level-sensitive
//  is_jump     in   1        core WB: retiring instruction is a jump
//  is_branch   in   1        core WB: retiring instruction is a branch
//  branched    in   1        core WB: retiring branch was taken
//  halt        in   1        core WB: halt syscall retired
//  en          out  1        core enable
//  state       out  3        FSM state: IDLE=0 RUN=1 STEP=2 PAUSE=3 HALTED=4
//  cyc_cnt     out  CntBits  number of enabled cycles
//  jump_cnt    out  CntBits  number of enabled cycles with is_jump=1
//  branch_cnt  out  CntBits  number of enabled cycles with is_branch=1
//  taken_cnt   out  CntBits  number of enabled cycles with is_branch=1 and branched=1
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, en=0, all counters 0, button history regs 0.
//  Edge detect: press_x = btn_x & ~btn_x_q, where btn_x_q is btn_x registered one cycle.
//   A held button produces exactly one press.
//  Press priority when several occur in the same cycle: pause > step > run.
//  en = (state==RUN)|(state==STEP). It is decoded from the state register only,
//   with no combinational path from any input.
//  FSM, evaluated each clk edge; halt=1 has top priority in every state except HALTED:
//   IDLE  : halt->HALTED; press_step->STEP; press_run->RUN; press_pause ignored.
//   RUN   : halt->HALTED; press_pause->PAUSE; press_step->STEP; press_run ignored.
//   STEP  : halt->HALTED; else ->PAUSE unconditionally. en=1 for exactly one cycle;
//           all presses in STEP are ignored and lost.
//   PAUSE : halt->HALTED; press_step->STEP; press_run->RUN.
//   HALTED: absorbing. en=0. Only rst_n exits. Counters freeze, stats_clr still clears.
//  Latency: a press in cycle N sets state and en in cycle N+1.
//   A halt sampled in cycle N drops en in cycle N+1.
//  Counters update on clk, in this order of precedence:
//   stats_clr=1             -> all counters 0 (overrides increment, any state).
//   else if en=1 & halt=0   -> cyc_cnt+1; jump_cnt+1 if is_jump;
//                              branch_cnt+1 if is_branch; taken_cnt+1 if is_branch&branched.
//   Each counter saturates at all-ones (2^CntBits-1); it never wraps.
//   branched without is_branch is not counted.
//  The cycle in which halt=1 is not counted, even if en=1.
//  Status inputs are ignored while en=0.
//  Reset mid-operation: state returns to IDLE and en=0 immediately (asynchronously).
//   Counters are 0. The core shares rst_n and restarts in step.
// TESTING
//  T1 reset: rst_n=0 for 3 cycles, inputs toggling -> en=0, state=0, all counters 0.
//  T2 run/halt: pulse run; run 10 cycles; halt=1 at cycle 11 ->
//     en=1 for cycles 1..11, state=4 at cycle 12, cyc_cnt=10.
//     Further run/step presses leave state=4.
//  T3 step: IDLE, press step; hold btn_step 5 cycles -> en high exactly 1 cycle,
//     state 2 then 3, cyc_cnt=1. Release and press again -> cyc_cnt=2.
//  T4 priority: run, step and pause rise in the same cycle from PAUSE -> state stays 3, en=0.
//     step and run rise together -> state=2.
//  T5 stats: in RUN drive is_branch=1 for 4 cycles with branched=1,0,1,1, plus is_jump=1 once
//     -> branch_cnt=4, taken_cnt=3, jump_cnt=1.
//     stats_clr for 1 cycle -> all counters 0 on the next edge.
//  T6 saturation (CntBits=4): RUN for 20 cycles -> cyc_cnt stops at 15.
//     Assert rst_n=0 mid-run -> en=0 and state=0 without waiting for a clk edge.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Core-side link of the run controller: the enable it drives and the WB-stage
// status it consumes. master = run controller, slave = CPU core.
interface cpu_run_ctrl_if;
    logic en;
    logic is_jump;
    logic is_branch;
    logic branched;
    logic halt;

    modport master (output en, input is_jump, is_branch, branched, halt);
    modport slave  (input en, output is_jump, is_branch, branched, halt);
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run / single-step / pause controller for the pipelined core, with sticky halt
// and saturating retirement statistics.
//
//   state  | meaning
//   IDLE   | after reset, core stopped, waiting for run or step
//   RUN    | core enabled every cycle
//   STEP   | core enabled for this one cycle, then PAUSE
//   PAUSE  | core stopped, resumable by run or step
//   HALTED | halt retired; absorbing until reset
module cpu_run_ctrl #(
    parameter int CntBits = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_run,
    input  logic               btn_step,
    input  logic               btn_pause,
    input  logic               stats_clr,
    cpu_run_ctrl_if.master     core,
    output logic [2:0]         state,
    output logic [CntBits-1:0] cyc_cnt,
    output logic [CntBits-1:0] jump_cnt,
    output logic [CntBits-1:0] branch_cnt,
    output logic [CntBits-1:0] taken_cnt
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RUN    = 3'd1;
    localparam logic [2:0] STEP   = 3'd2;
    localparam logic [2:0] PAUSE  = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;

    logic [2:0]         state_q, state_d;
    logic               btn_run_q, btn_step_q, btn_pause_q;
    logic               press_run, press_step, press_pause;
    logic               cnt_en;
    logic [CntBits-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CntBits-1:0] jump_cnt_q, jump_cnt_d;
    logic [CntBits-1:0] branch_cnt_q, branch_cnt_d;
    logic [CntBits-1:0] taken_cnt_q, taken_cnt_d;

    function automatic logic [CntBits-1:0] sat_inc(input logic [CntBits-1:0] v,
                                                   input logic inc);
        if (inc && (v != {CntBits{1'b1}})) return v + CntBits'(1);
        return v;
    endfunction

    assign press_run   = btn_run   & ~btn_run_q;
    assign press_step  = btn_step  & ~btn_step_q;
    assign press_pause = btn_pause & ~btn_pause_q;

    // Enable is a pure state decode so the core never sees a button glitch.
    assign core.en = (state_q == RUN) || (state_q == STEP);
    assign cnt_en  = core.en & ~core.halt;

    always_comb begin
        state_d = state_q;
        if (state_q != HALTED && core.halt) begin
            state_d = HALTED;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_step)      state_d = STEP;
                    else if (press_run)  state_d = RUN;
                end
                RUN: begin
                    if (press_pause)     state_d = PAUSE;
                    else if (press_step) state_d = STEP;
                end
                STEP:  state_d = PAUSE;
                PAUSE: begin
                    if (press_pause)     state_d = PAUSE;
                    else if (press_step) state_d = STEP;
                    else if (press_run)  state_d = RUN;
                end
                HALTED:  state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cyc_cnt_d    = cyc_cnt_q;
        jump_cnt_d   = jump_cnt_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (stats_clr) begin
            cyc_cnt_d    = '0;
            jump_cnt_d   = '0;
            branch_cnt_d = '0;
            taken_cnt_d  = '0;
        end else if (cnt_en) begin
            cyc_cnt_d    = sat_inc(cyc_cnt_q, 1'b1);
            jump_cnt_d   = sat_inc(jump_cnt_q, core.is_jump);
            branch_cnt_d = sat_inc(branch_cnt_q, core.is_branch);
            taken_cnt_d  = sat_inc(taken_cnt_q, core.is_branch & core.branched);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            btn_run_q    <= 1'b0;
            btn_step_q   <= 1'b0;
            btn_pause_q  <= 1'b0;
            cyc_cnt_q    <= '0;
            jump_cnt_q   <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            btn_run_q    <= btn_run;
            btn_step_q   <= btn_step;
            btn_pause_q  <= btn_pause;
            cyc_cnt_q    <= cyc_cnt_d;
            jump_cnt_q   <= jump_cnt_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign state      = state_q;
    assign cyc_cnt    = cyc_cnt_q;
    assign jump_cnt   = jump_cnt_q;
    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a 32-bit and a 4-bit instance share stimulus; a behavioural
// model queues expected outputs per edge and directed checks pin the key scenarios.
module tb_cpu_run_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_run = 0, btn_step = 0, btn_pause = 0, stats_clr = 0;
    logic is_jump = 0, is_branch = 0, branched = 0, halt = 0;

    logic [2:0]  state32, state4;
    logic [31:0] cyc32, jmp32, br32, tk32;
    logic [3:0]  cyc4, jmp4, br4, tk4;

    int n_vec = 0;
    int n_miss = 0;

    cpu_run_ctrl_if c32 ();
    cpu_run_ctrl_if c4 ();

    assign c32.is_jump = is_jump;   assign c4.is_jump = is_jump;
    assign c32.is_branch = is_branch; assign c4.is_branch = is_branch;
    assign c32.branched = branched; assign c4.branched = branched;
    assign c32.halt = halt;         assign c4.halt = halt;

    cpu_run_ctrl #(.CntBits(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
        .btn_pause(btn_pause), .stats_clr(stats_clr), .core(c32.master),
        .state(state32), .cyc_cnt(cyc32), .jump_cnt(jmp32),
        .branch_cnt(br32), .taken_cnt(tk32));

    cpu_run_ctrl #(.CntBits(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
        .btn_pause(btn_pause), .stats_clr(stats_clr), .core(c4.master),
        .state(state4), .cyc_cnt(cyc4), .jump_cnt(jmp4),
        .branch_cnt(br4), .taken_cnt(tk4));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic        en;
        longint      c32 [4];
        longint      c4 [4];
    } exp_t;

    exp_t sb[$];

    logic [2:0] m_state;
    logic       m_run_q, m_step_q, m_pause_q;
    longint     m32 [4];
    longint     m4 [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 3'd0;
        m_run_q = 0; m_step_q = 0; m_pause_q = 0;
        for (int i = 0; i < 4; i++) begin m32[i] = 0; m4[i] = 0; end
    endtask

    function automatic longint bump(input longint v, input bit inc, input longint max);
        return (inc && v < max) ? v + 1 : v;
    endfunction

    // Expected state and counters after the coming clock edge.
    task automatic model_edge(output exp_t e);
        bit pr, ps, pp, running;
        bit inc [4];
        logic [2:0] ns;
        pr = btn_run && !m_run_q;
        ps = btn_step && !m_step_q;
        pp = btn_pause && !m_pause_q;
        running = (m_state == 3'd1) || (m_state == 3'd2);
        if (halt && m_state != 3'd4) ns = 3'd4;
        else if (m_state == 3'd0) ns = ps ? 3'd2 : (pr ? 3'd1 : 3'd0);
        else if (m_state == 3'd1) ns = pp ? 3'd3 : (ps ? 3'd2 : 3'd1);
        else if (m_state == 3'd2) ns = 3'd3;
        else if (m_state == 3'd3) ns = pp ? 3'd3 : (ps ? 3'd2 : (pr ? 3'd1 : 3'd3));
        else ns = 3'd4;
        inc[0] = 1;
        inc[1] = is_jump;
        inc[2] = is_branch;
        inc[3] = is_branch && branched;
        for (int i = 0; i < 4; i++) begin
            if (stats_clr) begin
                m32[i] = 0; m4[i] = 0;
            end else if (running && !halt) begin
                m32[i] = bump(m32[i], inc[i], 64'hFFFF_FFFF);
                m4[i]  = bump(m4[i], inc[i], 15);
            end
        end
        m_state = ns;
        m_run_q = btn_run; m_step_q = btn_step; m_pause_q = btn_pause;
        e.st = ns;
        e.en = (ns == 3'd1) || (ns == 3'd2);
        for (int i = 0; i < 4; i++) begin e.c32[i] = m32[i]; e.c4[i] = m4[i]; end
    endtask

    task automatic cycle(input logic r, input logic s, input logic p, input logic c,
                         input logic j, input logic b, input logic t, input logic h);
        exp_t e;
        @(negedge clk);
        btn_run = r; btn_step = s; btn_pause = p; stats_clr = c;
        is_jump = j; is_branch = b; branched = t; halt = h;
        model_edge(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("state32", 64'(state32), 64'(e.st));
        check("en32", 64'(c32.en), 64'(e.en));
        check("cyc32", 64'(cyc32), e.c32[0]);
        check("jump32", 64'(jmp32), e.c32[1]);
        check("branch32", 64'(br32), e.c32[2]);
        check("taken32", 64'(tk32), e.c32[3]);
        check("state4", 64'(state4), 64'(e.st));
        check("cyc4", 64'(cyc4), e.c4[0]);
        check("jump4", 64'(jmp4), e.c4[1]);
        check("taken4", 64'(tk4), e.c4[3]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset: checked before any clock edge can act.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check({tag, "_en"}, 64'(c32.en), 64'd0);
        check({tag, "_state"}, 64'(state32), 64'd0);
        check({tag, "_state4"}, 64'(state4), 64'd0);
        check({tag, "_cyc"}, 64'(cyc32), 64'd0);
        btn_run = 0; btn_step = 0; btn_pause = 0; stats_clr = 0;
        is_jump = 0; is_branch = 0; branched = 0; halt = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // T1: reset held with toggling inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {btn_run, btn_step, btn_pause, stats_clr} = 4'($urandom);
            {is_jump, is_branch, branched, halt} = 4'($urandom);
            @(posedge clk);
            #1;
            check("rst_en", 64'(c32.en), 64'd0);
            check("rst_state", 64'(state32), 64'd0);
            check("rst_cnt", 64'(cyc32 | jmp32 | br32 | tk32), 64'd0);
        end
        @(negedge clk);
        btn_run = 0; btn_step = 0; btn_pause = 0; stats_clr = 0;
        is_jump = 0; is_branch = 0; branched = 0; halt = 0;
        rst_n = 1'b1;
        idle(2);

        // T2: run 10 counted cycles, halt on the 11th
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("t2_en_after_press", 64'(c32.en), 64'd1);
        idle(10);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        check("t2_halted", 64'(state32), 64'd4);
        check("t2_cyc", 64'(cyc32), 64'd10);
        cycle(1, 0, 0, 0, 1, 1, 1, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        check("t2_sticky", 64'(state32), 64'd4);
        check("t2_clr_in_halt", 64'(cyc32), 64'd0);
        async_reset("t2_rst");

        // T3: held step gives a single enabled cycle
        idle(1);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("t3_step", 64'(state32), 64'd2);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("t3_pause", 64'(state32), 64'd3);
        check("t3_cyc1", 64'(cyc32), 64'd1);
        idle(1);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("t3_cyc2", 64'(cyc32), 64'd2);

        // T4: press priority from PAUSE
        cycle(1, 1, 1, 0, 0, 0, 0, 0);
        check("t4_pause_wins", 64'(state32), 64'd3);
        check("t4_en", 64'(c32.en), 64'd0);
        idle(1);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        check("t4_step_wins", 64'(state32), 64'd2);
        idle(1);
        cycle(0, 0, 0, 0, 1, 1, 1, 0);
        check("t4_ignored_paused", 64'(jmp32), 64'd0);

        // T5: branch/jump statistics in RUN
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        check("t5_branch", 64'(br32), 64'd4);
        check("t5_taken", 64'(tk32), 64'd3);
        check("t5_jump", 64'(jmp32), 64'd1);
        check("t5_cyc", 64'(cyc32), 64'd5);
        cycle(0, 0, 0, 1, 1, 1, 1, 0);
        check("t5_clr", 64'(cyc32 | jmp32 | br32 | tk32), 64'd0);

        // T6: 4-bit counters saturate, then reset mid-run
        idle(20);
        check("t6_sat4", 64'(cyc4), 64'd15);
        check("t6_cyc32", 64'(cyc32), 64'd20);
        check("t6_running", 64'(state32), 64'd1);
        async_reset("t6_rst");
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
